// File: rtl/dict_pkg.sv
// Shared constants, codebook and controller state encoding for the
// dictionary-decompression stream path.
package dict_pkg;

    localparam int CHUNK_SIZE    = 4;
    localparam int CODEBOOK_SIZE = 8;
    localparam int INDEX_BITS    = $clog2(CODEBOOK_SIZE);

    // Entry k sits at element [k]; the leftmost literal is the highest index.
    localparam logic [CODEBOOK_SIZE-1:0][CHUNK_SIZE-1:0] CODEBOOK = {
        4'h7, 4'hC, 4'h8, 4'hF, 4'hB, 4'h9, 4'h2, 4'h0
    };

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        OUTPUT
    } dict_ctrl_state_t;

endpackage

// File: rtl/dict_decompressor.sv
// Hard-wired 8-entry dictionary lookup: one index in, one decoded chunk out.
module dict_decompressor
    import dict_pkg::*;
(
    input  logic [INDEX_BITS-1:0] index_i,
    output logic [CHUNK_SIZE-1:0] chunk_o
);

    assign chunk_o = CODEBOOK[index_i];

endmodule

// File: rtl/dict_stream_ctrl.sv
// Unpacks a word of dictionary indices one per cycle through a shared
// decompressor and presents the assembled chunk word on an output handshake.
module dict_stream_ctrl
    import dict_pkg::*;
#(
    parameter int IDX_PER_WORD = 8,
    parameter int CNT_BITS     = $clog2(IDX_PER_WORD)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [IDX_PER_WORD*INDEX_BITS-1:0] in_data,
    input  logic [CNT_BITS-1:0]               in_cnt,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [IDX_PER_WORD*CHUNK_SIZE-1:0] out_data,
    output logic [CNT_BITS-1:0]               out_cnt,
    output logic                              busy
);

    dict_ctrl_state_t                    state_q;
    logic [IDX_PER_WORD*INDEX_BITS-1:0]  data_q;
    logic [CNT_BITS-1:0]                 cnt_q;
    logic [IDX_PER_WORD*CHUNK_SIZE-1:0]  buf_q;
    logic [CNT_BITS-1:0]                 ptr_q;
    logic [CNT_BITS-1:0]                 ptr_d;
    logic [CNT_BITS-1:0]                 lastPtr;
    logic [INDEX_BITS-1:0]               decIndex;
    logic [CHUNK_SIZE-1:0]               decChunk;

    // A count of 0 means a full word, so n-1 falls out of the natural wrap.
    assign lastPtr  = cnt_q - 1'b1;
    assign ptr_d    = ptr_q + 1'b1;
    assign decIndex = data_q[int'(ptr_q)*INDEX_BITS +: INDEX_BITS];

    dict_decompressor u_decomp (
        .index_i (decIndex),
        .chunk_o (decChunk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        cnt_q   <= in_cnt;
                        buf_q   <= '0;
                        ptr_q   <= '0;
                        state_q <= DECODE;
                    end
                end
                DECODE: begin
                    buf_q[int'(ptr_q)*CHUNK_SIZE +: CHUNK_SIZE] <= decChunk;
                    if (ptr_q == lastPtr) begin
                        state_q <= OUTPUT;
                    end else begin
                        ptr_q <= ptr_d;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUTPUT);
    assign busy      = (state_q != IDLE);
    assign out_data  = buf_q;
    assign out_cnt   = cnt_q;

endmodule
